lcd_writer: RTL and testbench

- Host-side driver for the character LCD write interface (wr / cmd / dbus).
- Accepts byte requests from the CPU I/O decode through a valid/ready port and buffers them in a small FIFO.
- Replays each byte to the display with programmed setup, strobe-width, hold and post-write settle times. The display samples on the rising edge of wr.
- Applies a longer settle time after a clear-screen command.

---
 rtl/lcd_writer_pkg.sv | 32 +++
 rtl/lcd_writer_fifo.sv | 53 +++++
 rtl/lcd_writer.sv | 98 +++++++++
 tb/tb_lcd_writer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_writer_pkg.sv
// Shared types and constants for the character LCD write path.
// Included by the writer FSM and the bench's display model.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_SETTLE
    } lcd_state_t;

    localparam logic [7:0] LCD_CMD_CLEAR       = 8'h01;
    localparam int unsigned LCD_CMD_SETADDR_BIT = 7;
    localparam logic [6:0] LCD_LINE2_ADDR      = 7'h40;

    // A clear is any command byte with the set-address bit low and bit 0 high.
    function automatic logic is_clear(input logic c, input logic [7:0] d);
        return c && !d[LCD_CMD_SETADDR_BIT] && d[0];
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_writer_fifo.sv
// Small synchronous FIFO holding {cmd, data} requests ahead of the LCD strobe FSM.
// Head entry is presented combinationally on dout.
module lcd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_writer.sv
// Character LCD write driver: queues CPU bytes and replays each one with
// programmed setup / strobe / hold / settle timing on wr, cmd and dbus.
module lcd_writer
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned CHAR_DLY  = 8,
    parameter int unsigned CLEAR_DLY = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_cmd,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       busy,
    output logic       wr,
    output logic       cmd,
    output logic [7:0] dbus
);

    localparam int unsigned CW = $clog2(max4(CLEAR_DLY, PULSE_CYC, SETUP_CYC, HOLD_CYC) + 1);

    lcd_state_t  state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic        wr_nxt, cmd_nxt;
    logic [7:0]  dbus_nxt;
    logic        fifo_full, fifo_empty, pop;
    logic [8:0]  fifo_dout;

    assign in_ready = !fifo_full;
    assign busy     = !fifo_empty || (state != ST_IDLE);

    lcd_fifo #(.DEPTH(DEPTH), .WIDTH(9)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && !fifo_full),
        .pop   (pop),
        .din   ({in_cmd, in_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            wr    <= 1'b0;
            cmd   <= 1'b0;
            dbus  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            wr    <= wr_nxt;
            cmd   <= cmd_nxt;
            dbus  <= dbus_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_IDLE: if (!fifo_empty) begin
                state_nxt = ST_SETUP;
                cnt_nxt   = CW'(SETUP_CYC - 1);
            end
            ST_SETUP: if (cnt == '0) begin
                state_nxt = ST_PULSE;
                cnt_nxt   = CW'(PULSE_CYC - 1);
            end else cnt_nxt = cnt - 1'b1;
            ST_PULSE: if (cnt == '0) begin
                state_nxt = ST_HOLD;
                cnt_nxt   = CW'(HOLD_CYC - 1);
            end else cnt_nxt = cnt - 1'b1;
            ST_HOLD: if (cnt == '0) begin
                state_nxt = ST_SETTLE;
                cnt_nxt   = is_clear(cmd, dbus) ? CW'(CLEAR_DLY) : CW'(CHAR_DLY);
            end else cnt_nxt = cnt - 1'b1;
            ST_SETTLE: if (cnt == '0) state_nxt = ST_IDLE;
                       else cnt_nxt = cnt - 1'b1;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // wr is high exactly while the registered state is PULSE.
    always_comb begin
        pop      = (state == ST_IDLE) && !fifo_empty;
        wr_nxt   = (state_nxt == ST_PULSE);
        cmd_nxt  = pop ? fifo_dout[8]   : cmd;
        dbus_nxt = pop ? fifo_dout[7:0] : dbus;
    end

endmodule

// File: tb/tb_lcd_writer.sv
// Bench for lcd_writer: timeline reference model compared every clock, a
// display model fed by wr rising edges, directed tables and random traffic.
module tb_lcd_writer;
    import lcd_pkg::*;

    localparam int S = 2, P = 4, H = 2, CHR = 8, CLR = 64, DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, in_valid = 1'b0, in_cmd = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, busy, wr, cmd;
    logic [7:0] dbus;

    logic       rst0 = 1'b1, v0 = 1'b0, c0 = 1'b0;
    logic [7:0] d0 = '0;
    logic       rdy0, busy0, wr0, cmd0;
    logic [7:0] dbus0;

    lcd_writer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_cmd(in_cmd), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .wr(wr), .cmd(cmd), .dbus(dbus)
    );

    lcd_writer #(.CHAR_DLY(0)) dut0 (
        .clk(clk), .rst(rst0), .in_valid(v0), .in_cmd(c0), .in_data(d0),
        .in_ready(rdy0), .busy(busy0), .wr(wr0), .cmd(cmd0), .dbus(dbus0)
    );

    int n_cmp = 0, n_err = 0, cyc = 0;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a byte popped at cycle t0 occupies a fixed timeline of
    // S+P+H+delay+2 clocks; wr is high for phases [S, S+P).
    logic [8:0] mq[$];
    logic [8:0] m_cur = '0;
    bit         m_active = 0;
    int         m_phase = 0;

    function automatic bit ref_clear(input logic [8:0] b);
        return b[8] && !b[7] && b[0];
    endfunction

    function automatic int m_total(input logic [8:0] b);
        return S + P + H + (ref_clear(b) ? CLR : CHR) + 2;
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic c, input logic [7:0] d);
        bit idle, ready;
        if (r) begin
            mq.delete();
            m_active = 0;
            m_cur = '0;
        end else begin
            idle  = !m_active || (m_phase >= m_total(m_cur) - 1);
            ready = (mq.size() < DEPTH);
            if (idle && mq.size() > 0) begin
                m_cur = mq.pop_front();
                m_phase = 0;
                m_active = 1;
            end else if (!idle) begin
                m_phase++;
            end
            if (v && ready) mq.push_back({c, d});
        end
    endtask

    // Display model: updated on each rising edge of wr.
    logic [7:0] dmem [128];
    logic [6:0] daddr;
    int         rise_cyc[$];
    logic [8:0] rlog[$];
    logic       prev_wr = 1'b0;

    task automatic disp_reset();
        for (int i = 0; i < 128; i++) dmem[i] = 8'h20;
        daddr = '0;
        rise_cyc.delete();
        rlog.delete();
    endtask

    task automatic disp_apply(input logic c, input logic [7:0] d);
        if (ref_clear({c, d})) begin
            for (int i = 0; i < 128; i++) dmem[i] = 8'h20;
            daddr = '0;
        end else if (c && d[7]) begin
            daddr = d[6:0];
        end else if (!c) begin
            dmem[daddr] = d;
            daddr = daddr + 7'd1;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic c, input logic [7:0] d);
        bit m_wr, m_busy;
        rst = r; in_valid = v; in_cmd = c; in_data = d;
        model_edge(r, v, c, d);
        @(posedge clk);
        #1;
        cyc++;
        m_wr   = m_active && (m_phase >= S) && (m_phase < S + P);
        m_busy = (mq.size() > 0) || (m_active && (m_phase < m_total(m_cur) - 1));
        check("wr", 9'(wr), 9'(m_wr));
        check("cmd_dbus", {cmd, dbus}, m_cur);
        check("busy", 9'(busy), 9'(m_busy));
        check("in_ready", 9'(in_ready), 9'(mq.size() < DEPTH));
        if (wr && !prev_wr) begin
            rise_cyc.push_back(cyc);
            rlog.push_back({cmd, dbus});
            disp_apply(cmd, dbus);
        end
        prev_wr = wr;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic push_byte(input logic c, input logic [7:0] d);
        bit ok;
        for (int i = 0; i < 200; i++) begin
            ok = (mq.size() < DEPTH);
            step(1'b0, 1'b1, c, d);
            if (ok) return;
        end
        check("push_timeout", 9'd0, 9'd1);
    endtask

    task automatic wait_rises(input int n, input int budget);
        for (int i = 0; i < budget && rise_cyc.size() < n; i++) idle_n(1);
        check("rise_count", 9'(rise_cyc.size()), 9'(n));
    endtask

    typedef struct {
        logic       c;
        logic [7:0] d;
        int         gap;
    } vec_t;

    vec_t vecs[5];
    int   p, acc, rc, r0a, r0b;
    logic [7:0] b;

    initial begin
        vecs[0] = '{1'b1, LCD_CMD_CLEAR, -1};
        vecs[1] = '{1'b0, 8'h42, 74};
        vecs[2] = '{1'b1, {1'b1, LCD_LINE2_ADDR}, 18};
        vecs[3] = '{1'b0, 8'h48, 18};
        vecs[4] = '{1'b0, 8'h49, 18};

        // Reset state
        disp_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("rst_wr", 9'(wr), 9'd0);
        check("rst_bus", {cmd, dbus}, 9'h000);
        check("rst_busy", 9'(busy), 9'd0);
        check("rst_ready", 9'(in_ready), 9'd1);

        // Single character
        step(1'b0, 1'b1, 1'b0, 8'h41);
        p = cyc;
        idle_n(1);
        check("t1_bus", {cmd, dbus}, 9'h041);
        wait_rises(1, 40);
        idle_n(20);
        if (rise_cyc.size() > 0) check("t1_rise_at", 9'(rise_cyc[0] - p), 9'd3);
        check("t1_disp", 9'(dmem[0]), 9'h041);

        // Clear, then line 2 addressing
        step(1'b1, 1'b0, 1'b0, 8'h00);
        disp_reset();
        dmem[0] = 8'h58;
        foreach (vecs[i]) push_byte(vecs[i].c, vecs[i].d);
        wait_rises(5, 600);
        idle_n(20);
        for (int i = 0; i < 5 && i < rise_cyc.size(); i++) begin
            check("tbl_byte", rlog[i], {vecs[i].c, vecs[i].d});
            if (vecs[i].gap >= 0 && i > 0)
                check("tbl_gap", 9'(rise_cyc[i] - rise_cyc[i-1]), 9'(vecs[i].gap));
        end
        check("disp_B", 9'(dmem[0]), 9'h042);
        check("disp_H", 9'(dmem[LCD_LINE2_ADDR]), 9'h048);
        check("disp_I", 9'(dmem[LCD_LINE2_ADDR + 7'd1]), 9'h049);

        // Back-pressure: six bytes held valid while idle
        step(1'b1, 1'b0, 1'b0, 8'h00);
        disp_reset();
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            b = 8'h30 + 8'(acc);
            if (mq.size() < DEPTH) acc++;
            step(1'b0, 1'b1, 1'b0, b);
        end
        check("bp_accepts", 9'(acc), 9'd5);
        check("bp_ready_low", 9'(in_ready), 9'd0);
        push_byte(1'b0, 8'h35);
        wait_rises(6, 300);
        for (int i = 0; i < 6 && i < rlog.size(); i++)
            check("bp_order", rlog[i], 9'(8'h30 + i));

        // Reset during PULSE with bytes queued
        step(1'b1, 1'b0, 1'b0, 8'h00);
        disp_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'h60 + 8'(i));
        for (int i = 0; i < 20 && !wr; i++) idle_n(1);
        idle_n(1);
        check("mid_wr_high", 9'(wr), 9'd1);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("mid_rst_wr", 9'(wr), 9'd0);
        check("mid_rst_bus", {cmd, dbus}, 9'h000);
        check("mid_rst_busy", 9'(busy), 9'd0);
        check("mid_rst_ready", 9'(in_ready), 9'd1);
        rc = rise_cyc.size();
        idle_n(100);
        check("mid_no_strobe", 9'(rise_cyc.size()), 9'(rc));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic rr, vv, cc;
            logic [7:0] dd;
            rr = ($urandom_range(0, 399) == 0);
            vv = ($urandom_range(0, 3) == 0);
            cc = ($urandom_range(0, 2) == 0);
            dd = 8'($urandom);
            if (cc && $urandom_range(0, 3) == 0) dd = LCD_CMD_CLEAR;
            step(rr, vv, cc, dd);
        end

        // Zero settle delay instance: back-to-back characters
        rst = 1'b1; in_valid = 1'b0;
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0; v0 = 1'b1; c0 = 1'b0; d0 = 8'h50;
        @(posedge clk); #1;
        d0 = 8'h51;
        @(posedge clk); #1;
        v0 = 1'b0;
        r0a = -1; r0b = -1;
        prev_wr = wr0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (wr0 && !prev_wr) begin
                if (r0a < 0) r0a = i;
                else if (r0b < 0) r0b = i;
            end
            prev_wr = wr0;
        end
        check("dly0_seen", 9'((r0a >= 0) && (r0b >= 0)), 9'd1);
        if (r0a >= 0 && r0b >= 0) check("dly0_gap", 9'(r0b - r0a), 9'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
